// File: rtl/a2d_serf_pkg.sv
// Shared types and constants for the a2d_serf SPI A2D responder.
// Define ADC_RAMP_EN to replace conv_val with an internal per-channel ramp bank.
package a2d_serf_pkg;

    typedef enum logic {
        CMD = 1'b0,
        RD  = 1'b1
    } state_t;

    localparam int          FRM_W      = 16;
    localparam int          BCNT_W     = 5;
    localparam int          CMD_CH_MSB = 13;
    localparam int          CMD_CH_LSB = 11;
    localparam logic [11:0] RAMP_STEP  = 12'h010;

    function automatic logic [BCNT_W-1:0] bcnt_sat_inc(input logic [BCNT_W-1:0] cnt);
        if (cnt == 5'd31) begin
            return cnt;
        end else begin
            return cnt + 5'd1;
        end
    endfunction

endpackage

// File: rtl/a2d_serf_spi_serf_core.sv
// SPI serf datapath: pin synchronizers, edge detection, bit counter,
// rx/tx shift registers and MISO gating.
module spi_serf_core
    import a2d_serf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              ld_tx,
    input  logic [FRM_W-1:0]  tx_data,
    output logic              MISO,
    output logic [FRM_W-1:0]  rx_data,
    output logic              frm_start,
    output logic              frm_end,
    output logic [BCNT_W-1:0] bit_cnt
);

    logic [2:0]        ss_r;
    logic [2:0]        sclk_r;
    logic [1:0]        mosi_r;
    logic [FRM_W-1:0]  rx_shft_r;
    logic [FRM_W-1:0]  tx_shft_r;
    logic [BCNT_W-1:0] bit_cnt_r;
    logic              sclk_rise_s;
    logic              sclk_fall_s;

    // Two-flop synchronizers; SS_n and SCLK carry a third flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_r   <= 3'b111;
            sclk_r <= 3'b111;
            mosi_r <= 2'b00;
        end else begin
            ss_r   <= {ss_r[1:0], SS_n};
            sclk_r <= {sclk_r[1:0], SCLK};
            mosi_r <= {mosi_r[0], MOSI};
        end
    end

    assign frm_start   = ss_r[2] & ~ss_r[1];
    assign frm_end     = ss_r[1] & ~ss_r[2];
    assign sclk_rise_s = sclk_r[1] & ~sclk_r[2];
    assign sclk_fall_s = sclk_r[2] & ~sclk_r[1];

    // Receive shifter and saturating bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shft_r <= 16'h0000;
            bit_cnt_r <= 5'd0;
        end else if (frm_start) begin
            bit_cnt_r <= 5'd0;
        end else if (sclk_rise_s) begin
            rx_shft_r <= {rx_shft_r[FRM_W-2:0], mosi_r[1]};
            bit_cnt_r <= bcnt_sat_inc(bit_cnt_r);
        end else begin
            rx_shft_r <= rx_shft_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Transmit shifter; the leading SCLK fall precedes any sample, so the
    // MSB is held until the first rise has been counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_r <= 16'h0000;
        end else if (ld_tx) begin
            tx_shft_r <= tx_data;
        end else if (sclk_fall_s && (bit_cnt_r != 5'd0)) begin
            tx_shft_r <= {tx_shft_r[FRM_W-2:0], 1'b0};
        end else begin
            tx_shft_r <= tx_shft_r;
        end
    end

    assign MISO    = tx_shft_r[FRM_W-1] & ~ss_r[2];
    assign rx_data = rx_shft_r;
    assign bit_cnt = bit_cnt_r;

endmodule

// File: rtl/a2d_serf.sv
// 8-channel 12-bit A2D SPI responder: command frame selects channel, next frame returns it.
// Optional build macro ADC_RAMP_EN swaps conv_val for an internal ramp bank.
module a2d_serf
    import a2d_serf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] conv_val,
    output logic [2:0]  chnl,
    output logic        cmd_vld,
    output logic        rd_done,
    output logic        frm_err
);

    state_t            state_r, state_nxt_s;
    logic [2:0]        chnl_r, chnl_nxt_s;
    logic [11:0]       result_r, result_nxt_s, sample_s;
    logic              cmd_vld_r, cmd_vld_nxt_s;
    logic              rd_done_r, rd_done_nxt_s;
    logic              frm_err_r, frm_err_nxt_s;
    logic [FRM_W-1:0]  rx_data_s;
    logic [FRM_W-1:0]  tx_data_s;
    logic [BCNT_W-1:0] bit_cnt_s;
    logic              frm_start_s;
    logic              frm_end_s;
    logic              full_frm_s;
    logic [2:0]        rx_ch_s;

    spi_serf_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .ld_tx     (frm_start_s),
        .tx_data   (tx_data_s),
        .MISO      (MISO),
        .rx_data   (rx_data_s),
        .frm_start (frm_start_s),
        .frm_end   (frm_end_s),
        .bit_cnt   (bit_cnt_s)
    );

    assign tx_data_s  = (state_r == RD) ? {4'h0, result_r} : 16'h0000;
    assign full_frm_s = (bit_cnt_s == 5'(FRM_W));
    assign rx_ch_s    = rx_data_s[CMD_CH_MSB:CMD_CH_LSB];

`ifdef ADC_RAMP_EN
    logic [11:0] ramp_r [8];
    logic        conv_unused_s;

    assign conv_unused_s = ^conv_val;
    assign sample_s      = ramp_r[rx_ch_s];

    // Ramp bank: the channel just read advances by RAMP_STEP, wrapping at 4096
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                ramp_r[i] <= 12'h000;
            end
        end else if (rd_done_nxt_s) begin
            ramp_r[chnl_r] <= ramp_r[chnl_r] + RAMP_STEP;
        end else begin
            ramp_r[chnl_r] <= ramp_r[chnl_r];
        end
    end
`else
    assign sample_s = conv_val;
`endif

    // Frame decode at SS_n rise: next state, captured fields and pulse requests
    always_comb begin
        state_nxt_s   = state_r;
        chnl_nxt_s    = chnl_r;
        result_nxt_s  = result_r;
        cmd_vld_nxt_s = 1'b0;
        rd_done_nxt_s = 1'b0;
        frm_err_nxt_s = 1'b0;
        case (state_r)
            CMD: begin
                if (frm_end_s) begin
                    if (full_frm_s && (rx_data_s[15:14] == 2'b00)) begin
                        chnl_nxt_s    = rx_ch_s;
                        result_nxt_s  = sample_s;
                        cmd_vld_nxt_s = 1'b1;
                        state_nxt_s   = RD;
                    end else begin
                        frm_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = CMD;
                end
            end
            RD: begin
                if (frm_end_s) begin
                    if (full_frm_s) begin
                        rd_done_nxt_s = 1'b1;
                        state_nxt_s   = CMD;
                    end else begin
                        frm_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = RD;
                end
            end
            default: begin
                state_nxt_s = CMD;
            end
        endcase
    end

    // State, captured channel/result and registered one-clk pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= CMD;
            chnl_r    <= 3'd0;
            result_r  <= 12'h000;
            cmd_vld_r <= 1'b0;
            rd_done_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            chnl_r    <= chnl_nxt_s;
            result_r  <= result_nxt_s;
            cmd_vld_r <= cmd_vld_nxt_s;
            rd_done_r <= rd_done_nxt_s;
            frm_err_r <= frm_err_nxt_s;
        end
    end

    assign chnl    = chnl_r;
    assign cmd_vld = cmd_vld_r;
    assign rd_done = rd_done_r;
    assign frm_err = frm_err_r;

endmodule
